// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The datapath (master) supplies instruction fields and status; the controller (slave) drives controls.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       data_src;
    logic       reg_write;
    logic       alu_src_a;
    logic       instr_done;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_operation;
    logic [3:0] state;

    modport master (
        output opcode, func, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, data_src, reg_write,
               alu_src_a, instr_done, pc_src, alu_src_b, alu_operation, state
    );

    modport slave (
        input  opcode, func, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, data_src, reg_write,
               alu_src_a, instr_done, pc_src, alu_src_b, alu_operation, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: one registered state, Moore/Mealy control outputs.
// Controls are forced low while rst is high; the state output always shows the register.
module multicycle_controller (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.slave bus
);
    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StExecR   = 4'd2;
    localparam logic [3:0] StExecI   = 4'd3;
    localparam logic [3:0] StMemAddr = 4'd4;
    localparam logic [3:0] StMemRd   = 4'd5;
    localparam logic [3:0] StMemWr   = 4'd6;
    localparam logic [3:0] StWbR     = 4'd7;
    localparam logic [3:0] StWbI     = 4'd8;
    localparam logic [3:0] StWbMem   = 4'd9;
    localparam logic [3:0] StBranch  = 4'd10;
    localparam logic [3:0] StJump    = 4'd11;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    logic [3:0] state_q, state_d;

    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, data_src, reg_write, alu_src_a, instr_done;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_operation;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        data_src      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        instr_done    = 1'b0;
        pc_src        = 2'b00;
        alu_src_b     = 2'b00;
        alu_operation = AluAnd;

        case (state_q)
            StFetch: begin
                mem_read      = 1'b1;
                alu_src_b     = 2'b01;
                alu_operation = AluAdd;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b     = 2'b11;
                alu_operation = AluAdd;
                case (bus.opcode)
                    OpRtype:      state_d = (bus.func != 6'd0) ? StExecR : StFetch;
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpAddi, OpAndi: state_d = StExecI;
                    OpBeq, OpBne: state_d = StBranch;
                    OpJ:          state_d = StJump;
                    default:      state_d = StFetch;
                endcase
                instr_done = (state_d == StFetch);
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (bus.func)
                    6'b100000: alu_operation = AluAdd;
                    6'b100010: alu_operation = AluSub;
                    6'b100100: alu_operation = AluAnd;
                    6'b100101: alu_operation = AluOr;
                    6'b101010: alu_operation = AluSlt;
                    default:   alu_operation = AluAnd;
                endcase
                state_d = StWbR;
            end
            StExecI: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_operation = (bus.opcode == OpAndi) ? AluAnd : AluAdd;
                state_d       = StWbI;
            end
            StMemAddr: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_operation = AluAdd;
                state_d       = (bus.opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StWbR: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StWbI: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                data_src   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                alu_operation = AluSub;
                pc_src        = 2'b01;
                pc_write      = ((bus.opcode == OpBeq) && bus.zero) ||
                                ((bus.opcode == OpBne) && !bus.zero);
                instr_done    = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            data_src      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            instr_done    = 1'b0;
            pc_src        = 2'b00;
            alu_src_b     = 2'b00;
            alu_operation = 3'b000;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.data_src      = data_src;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.instr_done    = instr_done;
    assign bus.pc_src        = pc_src;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_operation = alu_operation;
    assign bus.state         = state_q;
endmodule
